result_byte_serializer: RTL and testbench

Downstream stage of the pipelined processing core and its control unit. When the control unit raises `begin_transmission`, the block latches one `DATA_WIDTH`-bit result word (an element of `par_result` or `man_result`, selected upstream) and splits it into bytes. It hands the bytes one at a time to the UART transmitter through a start/busy handshake. After the last byte has left the UART it pulses `tx_sent`, which advances the control FSM to its next state (SHIFT_MEM, next element, or idle).

---
 rtl/serializer_pkg.sv | 5 +
 rtl/result_byte_serializer.sv | 81 ++++++++
 tb/tb_result_byte_serializer.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/serializer_pkg.sv
// serializer_pkg: shared types and constants for the result byte serializer
package serializer_pkg;
   localparam int BYTE_W = 8;
   typedef enum logic [2:0] {IDLE, WAIT_FREE, START, WAIT_ACK, WAIT_DONE, DONE} state_t;
endpackage

// File: rtl/result_byte_serializer.sv
// result_byte_serializer: latches a result word and hands it byte by byte to a UART via start/busy
module result_byte_serializer
   import serializer_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter bit MSB_FIRST  = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  begin_transmission,
   input  logic [DATA_WIDTH-1:0] result,
   input  logic                  tx_busy,
   output logic [BYTE_W-1:0]     tx_data,
   output logic                  tx_start,
   output logic                  tx_sent,
   output logic                  busy
);
   localparam int NBYTES = DATA_WIDTH / BYTE_W;
   localparam int CW = NBYTES > 1 ? $clog2(NBYTES) : 1;
   localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

   if (DATA_WIDTH < BYTE_W || DATA_WIDTH % BYTE_W != 0) begin : g_bad_width
      $fatal(1, "DATA_WIDTH must be a non-zero multiple of 8");
   end

   state_t                state, nxt;
   logic [DATA_WIDTH-1:0] shreg;
   logic [CW-1:0]         cnt;
   logic [BYTE_W-1:0]     lead_byte;
   logic [DATA_WIDTH-1:0] shifted;
   logic                  accept, load, advance;

   assign lead_byte = MSB_FIRST ? shreg[DATA_WIDTH-1 -: BYTE_W] : shreg[BYTE_W-1:0];
   assign shifted   = MSB_FIRST ? shreg << BYTE_W : shreg >> BYTE_W;
   assign accept    = state == IDLE && begin_transmission;
   assign load      = state == WAIT_FREE && !tx_busy;
   assign advance   = state == WAIT_DONE && !tx_busy && cnt != LAST;
   assign busy      = state != IDLE;

   // state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= nxt;
   end

   // next-state logic: one byte per WAIT_FREE..WAIT_DONE round, DONE after the last
   always_comb begin
      nxt = state;
      case (state)
         IDLE:      nxt = begin_transmission ? WAIT_FREE : IDLE;
         WAIT_FREE: nxt = tx_busy ? WAIT_FREE : START;
         START:     nxt = WAIT_ACK;
         WAIT_ACK:  nxt = tx_busy ? WAIT_DONE : WAIT_ACK;
         WAIT_DONE: nxt = tx_busy ? WAIT_DONE : (cnt == LAST ? DONE : WAIT_FREE);
         DONE:      nxt = IDLE;
         default:   nxt = IDLE;
      endcase
   end

   // datapath: word latch, byte shift, counter and registered UART strobes
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         shreg    <= '0;
         cnt      <= '0;
         tx_data  <= '0;
         tx_start <= 1'b0;
         tx_sent  <= 1'b0;
      end else begin
         tx_start <= nxt == START;
         tx_sent  <= nxt == DONE;
         if (accept) begin
            shreg <= result;
            cnt   <= '0;
         end else if (advance) begin
            shreg <= shifted;
            cnt   <= cnt + CW'(1);
         end
         if (load) tx_data <= lead_byte;
      end
   end
endmodule

// File: tb/tb_result_byte_serializer.sv
// tb_result_byte_serializer: table, hand-written and random checks of three serializer variants
module tb_result_byte_serializer;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n = 1'b1;
   int          cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic        begin_s     [3] = '{1'b0, 1'b0, 1'b0};
   logic        ext_busy    [3] = '{1'b0, 1'b0, 1'b0};
   logic        ubusy       [3] = '{1'b0, 1'b0, 1'b0};
   logic        tx_busy_s   [3];
   logic [31:0] res         [3] = '{32'h0, 32'h0, 32'h0};
   logic [7:0]  tx_data_s   [3];
   logic        tx_start_s  [3];
   logic        tx_sent_s   [3];
   logic        busy_s      [3];
   int          ucnt        [3] = '{0, 0, 0};
   int          busy_len    [3] = '{1, 1, 1};
   int          sent_cnt    [3] = '{0, 0, 0};
   int          sent_cyc    [3] = '{0, 0, 0};
   int          fall_cyc    [3] = '{0, 0, 0};
   logic        prev_busy   [3] = '{1'b0, 1'b0, 1'b0};
   logic [7:0]  got_q       [3][$];
   int          start_q     [3][$];

   int checks = 0;
   int errors = 0;

   assign tx_busy_s[0] = ubusy[0] | ext_busy[0];
   assign tx_busy_s[1] = ubusy[1] | ext_busy[1];
   assign tx_busy_s[2] = ubusy[2] | ext_busy[2];

   result_byte_serializer u_msb (
      .clk(clk), .reset(rst_n), .begin_transmission(begin_s[0]), .result(res[0]),
      .tx_busy(tx_busy_s[0]), .tx_data(tx_data_s[0]), .tx_start(tx_start_s[0]),
      .tx_sent(tx_sent_s[0]), .busy(busy_s[0]));

   result_byte_serializer #(.DATA_WIDTH(32), .MSB_FIRST(1'b0)) u_lsb (
      .clk(clk), .reset(rst_n), .begin_transmission(begin_s[1]), .result(res[1]),
      .tx_busy(tx_busy_s[1]), .tx_data(tx_data_s[1]), .tx_start(tx_start_s[1]),
      .tx_sent(tx_sent_s[1]), .busy(busy_s[1]));

   result_byte_serializer #(.DATA_WIDTH(8)) u_w8 (
      .clk(clk), .reset(rst_n), .begin_transmission(begin_s[2]), .result(res[2][7:0]),
      .tx_busy(tx_busy_s[2]), .tx_data(tx_data_s[2]), .tx_start(tx_start_s[2]),
      .tx_sent(tx_sent_s[2]), .busy(busy_s[2]));

   // UART stand-in: goes busy after a start strobe for busy_len cycles; unaffected by reset
   always @(posedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (tx_start_s[i]) begin
            ubusy[i] <= 1'b1;
            ucnt[i]  <= busy_len[i];
         end else if (ucnt[i] > 1) begin
            ucnt[i] <= ucnt[i] - 1;
         end else begin
            ucnt[i]  <= 0;
            ubusy[i] <= 1'b0;
         end
      end
   end

   // monitor: record started bytes, sent pulses and busy falls away from the active edge
   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (tx_start_s[i]) begin
            got_q[i].push_back(tx_data_s[i]);
            start_q[i].push_back(cyc);
         end
         if (tx_sent_s[i]) begin
            sent_cnt[i] = sent_cnt[i] + 1;
            sent_cyc[i] = cyc;
         end
         if (prev_busy[i] && !tx_busy_s[i]) fall_cyc[i] = cyc;
         prev_busy[i] = tx_busy_s[i];
      end
   end

   function automatic int nb(input int inst);
      return inst == 2 ? 1 : 4;
   endfunction

   // reference: bytes in send order, first byte in the most significant position
   function automatic logic [31:0] model_seq(input int inst, input logic [31:0] word);
      logic [31:0] r = 32'h0;
      int n = nb(inst);
      for (int i = 0; i < n; i++) begin
         int pos = (inst == 1) ? i : n - 1 - i;
         r = (r << 8) | ((word >> (8 * pos)) & 32'hFF);
      end
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int inst, input logic [31:0] word, input logic [31:0] exp,
                       input int blen, input int pre_busy, input bit disturb);
      int n, base, s0, rel;
      n = nb(inst);
      base = got_q[inst].size();
      s0 = sent_cnt[inst];
      rel = 0;
      busy_len[inst] = blen;
      if (pre_busy > 0) ext_busy[inst] = 1'b1;
      res[inst] = word;
      begin_s[inst] = 1'b1;
      tick();
      begin_s[inst] = 1'b0;
      if (pre_busy > 0) begin
         repeat (pre_busy - 1) tick();
         ext_busy[inst] = 1'b0;
         rel = cyc;
      end
      for (int k = 0; k < 3000 && sent_cnt[inst] == s0; k++) begin
         tick();
         if (disturb && k == 15) begin
            begin_s[inst] = 1'b1;
            res[inst] = 32'hFFFF_FFFF;
         end else begin
            begin_s[inst] = 1'b0;
         end
      end
      begin_s[inst] = 1'b0;
      repeat (20) tick();
      chk("sent_pulses", 32'(sent_cnt[inst] - s0), 32'd1);
      chk("byte_count", 32'(got_q[inst].size() - base), 32'(n));
      for (int i = 0; i < n; i++)
         if (base + i < got_q[inst].size())
            chk("byte", 32'(got_q[inst][base + i]), (exp >> (8 * (n - 1 - i))) & 32'hFF);
      chk("sent_latency", 32'(sent_cyc[inst] - fall_cyc[inst]), 32'd1);
      chk("tx_data_hold", 32'(tx_data_s[inst]), exp & 32'hFF);
      chk("busy_idle", 32'(busy_s[inst]), 32'd0);
      if (pre_busy > 0 && got_q[inst].size() > base)
         chk("busy_release_to_start", 32'(start_q[inst][base] - rel), 32'd1);
   endtask

   typedef struct {
      int          inst;
      logic [31:0] word;
      logic [31:0] exp;
      int          blen;
      int          pre_busy;
      bit          disturb;
   } vec_t;

   vec_t tbl [6];

   initial begin
      int base, s0;
      tbl[0] = '{0, 32'h1234_5678, 32'h1234_5678, 10, 0, 1'b0};
      tbl[1] = '{0, 32'h1234_5678, 32'h1234_5678, 10, 0, 1'b1};
      tbl[2] = '{0, 32'hCAFE_F00D, 32'hCAFE_F00D, 3, 7, 1'b0};
      tbl[3] = '{1, 32'hA1B2_C3D4, 32'hD4C3_B2A1, 5, 0, 1'b0};
      tbl[4] = '{2, 32'h0000_005A, 32'h0000_005A, 10, 0, 1'b0};
      tbl[5] = '{1, 32'h0000_00FF, 32'hFF00_0000, 1, 0, 1'b0};

      #1 rst_n = 1'b0;
      for (int c = 0; c < 6; c++) begin
         for (int i = 0; i < 3; i++) begin
            begin_s[i]  = 1'($urandom_range(0, 1));
            ext_busy[i] = 1'($urandom_range(0, 1));
            res[i]      = $urandom;
         end
         @(negedge clk);
         for (int i = 0; i < 3; i++)
            chk("reset_outputs", 32'({tx_data_s[i], tx_start_s[i], tx_sent_s[i], busy_s[i]}), 32'd0);
      end
      for (int i = 0; i < 3; i++) begin
         begin_s[i] = 1'b0;
         ext_busy[i] = 1'b0;
      end
      tick();
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         for (int i = 0; i < 3; i++) chk("idle_after_reset", 32'(busy_s[i]), 32'd0);
      end

      foreach (tbl[t])
         send(tbl[t].inst, tbl[t].word, tbl[t].exp, tbl[t].blen, tbl[t].pre_busy, tbl[t].disturb);

      base = got_q[0].size();
      s0 = sent_cnt[0];
      busy_len[0] = 10;
      res[0] = 32'h1234_5678;
      begin_s[0] = 1'b1;
      tick();
      begin_s[0] = 1'b0;
      for (int k = 0; k < 500 && got_q[0].size() - base < 2; k++) tick();
      chk("abort_second_start", 32'(got_q[0].size() - base), 32'd2);
      rst_n = 1'b0;
      @(negedge clk);
      chk("abort_outputs", 32'({tx_data_s[0], tx_start_s[0], tx_sent_s[0], busy_s[0]}), 32'd0);
      tick();
      rst_n = 1'b1;
      repeat (40) tick();
      chk("abort_no_sent", 32'(sent_cnt[0] - s0), 32'd0);
      chk("abort_no_restart", 32'(got_q[0].size() - base), 32'd2);
      send(0, 32'h0000_00FF, 32'h0000_00FF, 10, 0, 1'b0);

      for (int r = 0; r < 20; r++) begin
         int inst;
         logic [31:0] w;
         inst = $urandom_range(0, 2);
         w = $urandom;
         if (inst == 2) w = w & 32'hFF;
         send(inst, w, model_seq(inst, w), $urandom_range(1, 12), 0, 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end
endmodule
